// File: rtl/ofm_sched_pkg.sv
// Shared types and constants for the OFM write scheduler.
// States, byte width and lane-to-offset mapping.
package ofm_sched_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_RUN   = ST_RUN,
    S_FLUSH = ST_FLUSH,
    S_DONE  = ST_DONE
  } state_e;

  localparam int BYTE_W = 8;

  localparam logic [1:0] LANE_OFF [4] = '{
    2'd0, 2'd1, 2'd2, 2'd3
  };

endpackage

// File: rtl/ofm_write_scheduler_if.sv
// Engine request bus plus memory byte-write port.
// master = scheduler side, slave = engines/memory side.
interface ofm_write_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8
);
  import ofm_sched_pkg::*;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*BYTE_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      ofm_write;
  logic [ADDR_W-1:0]         ofm_address;
  logic [1:0]                ofm_offset;
  logic [BYTE_W-1:0]         ofm_data;
  logic                      ofm_write_out;

  modport master (
    input  req_valid, req_data,
    output req_ready, ofm_write, ofm_address,
    output ofm_offset, ofm_data, ofm_write_out
  );

  modport slave (
    output req_valid, req_data,
    input  req_ready, ofm_write, ofm_address,
    input  ofm_offset, ofm_data, ofm_write_out
  );

endinterface

// File: rtl/ofm_rr_arbiter.sv
// Combinational round-robin picker: first eligible
// requester at or after ptr, wrapping.
module ofm_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      index,
  output logic               any
);

  always_comb begin
    int i;
    grant = '0;
    index = '0;
    any   = 1'b0;
    i     = 0;
    // walk backwards so the nearest requester wins last
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      i = (int'(ptr) + k) % NUM_REQ;
      if (eligible[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        index    = IW'(i);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ofm_write_scheduler.sv
// Shares the OFM byte-write port among NUM_REQ engines and
// issues one dump pulse once every engine finished its layer.
module ofm_write_scheduler
  import ofm_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int NUM_PIXELS = 128,
  parameter int ADDR_W     = 8
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 start,
  ofm_write_scheduler_if.master bus,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(NUM_PIXELS + 1);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CW-1:0] FULL   = CW'(NUM_PIXELS);
  localparam logic [CW-1:0] PENULT = CW'(NUM_PIXELS - 1);
  localparam logic [IW-1:0] TOP    = IW'(NUM_REQ - 1);

  state_e             state;
  logic [CW-1:0]      cnt [NUM_REQ];
  logic [IW-1:0]      ptr;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      gidx;
  logic               any;
  logic               last;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++)
      elig[i] = (state == S_RUN) && (cnt[i] < FULL)
                && bus.req_valid[i];
  end

  ofm_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .eligible (elig),
    .ptr      (ptr),
    .grant    (grant),
    .index    (gidx),
    .any      (any)
  );

  assign bus.req_ready = grant;
  assign busy = (state == S_RUN) || (state == S_FLUSH);
  assign done = (state == S_DONE);

  // true when this transfer fills the last open slot
  always_comb begin
    last = any;
    for (int i = 0; i < NUM_REQ; i++)
      if (!((cnt[i] == FULL) ||
            (grant[i] && cnt[i] == PENULT)))
        last = 1'b0;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      ptr               <= '0;
      for (int i = 0; i < NUM_REQ; i++)
        cnt[i] <= '0;
      bus.ofm_write     <= 1'b0;
      bus.ofm_write_out <= 1'b0;
      bus.ofm_address   <= '0;
      bus.ofm_offset    <= '0;
      bus.ofm_data      <= '0;
    end else begin
      bus.ofm_write     <= any;
      bus.ofm_write_out <= (state == S_FLUSH);
      if (any) begin
        bus.ofm_address <= ADDR_W'(cnt[gidx]);
        bus.ofm_offset  <= LANE_OFF[gidx];
        bus.ofm_data    <= bus.req_data[gidx*BYTE_W +: BYTE_W];
        cnt[gidx]       <= cnt[gidx] + 1'b1;
        ptr             <= (gidx == TOP) ? '0 : gidx + 1'b1;
      end
      unique case (1'b1)
        (state == S_RUN): begin
          if (last) state <= S_FLUSH;
        end
        (state == S_FLUSH): begin
          state <= S_DONE;
        end
        default: begin
          if (start) begin
            state <= S_RUN;
            for (int i = 0; i < NUM_REQ; i++)
              cnt[i] <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ofm_write_scheduler.sv
// Bench for ofm_write_scheduler: big (128 px) and small (2 px)
// instances, directed stimulus, queue-based scoreboard.
module tb_ofm_write_scheduler;

  localparam int NR  = 4;
  localparam int AW  = 8;
  localparam int NPB = 128;
  localparam int NPS = 2;

  typedef struct packed {
    logic          dump;
    logic [AW-1:0] addr;
    logic [1:0]    off;
    logic [7:0]    data;
  } ev_t;

  logic                  clock = 1'b0;
  logic                  rst_n = 1'b1;
  logic [1:0]            start = '0;
  logic [1:0]            busy;
  logic [1:0]            done;
  logic [1:0][NR-1:0]    vld = '0;
  logic [1:0][NR*8-1:0]  dat = '0;

  int total = 0;
  int bad   = 0;
  ev_t q0[$];
  ev_t q1[$];

  int mst  [2];
  int mptr [2];
  int mcnt [2][NR];

  always #5 clock = ~clock;

  ofm_write_scheduler_if #(.NUM_REQ(NR), .ADDR_W(AW)) b0 ();
  ofm_write_scheduler_if #(.NUM_REQ(NR), .ADDR_W(AW)) b1 ();

  assign b0.req_valid = vld[0];
  assign b0.req_data  = dat[0];
  assign b1.req_valid = vld[1];
  assign b1.req_data  = dat[1];

  ofm_write_scheduler #(
    .NUM_REQ(NR), .NUM_PIXELS(NPB), .ADDR_W(AW)
  ) u_big (
    .clock(clock), .rst_n(rst_n), .start(start[0]),
    .bus(b0), .busy(busy[0]), .done(done[0])
  );

  ofm_write_scheduler #(
    .NUM_REQ(NR), .NUM_PIXELS(NPS), .ADDR_W(AW)
  ) u_small (
    .clock(clock), .rst_n(rst_n), .start(start[1]),
    .bus(b1), .busy(busy[1]), .done(done[1])
  );

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  task automatic push(int u, ev_t e);
    if (u == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic mon(int u, logic w, logic wo,
                     logic [AW-1:0] a, logic [1:0] o,
                     logic [7:0] d);
    ev_t e;
    int  n;
    if (w || wo) begin
      n = (u == 0) ? q0.size() : q1.size();
      if (n == 0) begin
        chk($sformatf("unexpected_evt%0d", u),
            64'({w, wo}), 64'd0);
      end else begin
        if (u == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        if (e.dump)
          chk($sformatf("dump%0d", u),
              64'({w, wo}), 64'(2'b01));
        else
          chk($sformatf("write%0d", u),
              64'({w, wo, a, o, d}),
              64'({2'b10, e.addr, e.off, e.data}));
      end
    end
  endtask

  always @(negedge clock)
    mon(0, b0.ofm_write, b0.ofm_write_out,
        b0.ofm_address, b0.ofm_offset, b0.ofm_data);

  always @(negedge clock)
    mon(1, b1.ofm_write, b1.ofm_write_out,
        b1.ofm_address, b1.ofm_offset, b1.ofm_data);

  // reference: 0 idle, 1 run, 2 flush, 3 done
  task automatic model(int u);
    logic [NR-1:0] rdy;
    logic [NR-1:0] eg;
    int  g, i, np;
    logic fin;
    ev_t e;
    np  = (u == 0) ? NPB : NPS;
    rdy = (u == 0) ? b0.req_ready : b1.req_ready;
    chk($sformatf("busy%0d", u), 64'(busy[u]),
        64'(mst[u] == 1 || mst[u] == 2));
    chk($sformatf("done%0d", u), 64'(done[u]),
        64'(mst[u] == 3));
    g = -1;
    for (int k = 0; k < NR; k++) begin
      i = (mptr[u] + k) % NR;
      if (g < 0 && mst[u] == 1 && mcnt[u][i] < np
          && vld[u][i])
        g = i;
    end
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    chk($sformatf("ready%0d", u), 64'(rdy), 64'(eg));
    case (mst[u])
      1: if (g >= 0) begin
        e.dump = 1'b0;
        e.addr = AW'(mcnt[u][g]);
        e.off  = 2'(g);
        e.data = dat[u][g*8 +: 8];
        push(u, e);
        mcnt[u][g]++;
        mptr[u] = (g + 1) % NR;
        fin = 1'b1;
        for (int k = 0; k < NR; k++)
          if (mcnt[u][k] != np) fin = 1'b0;
        if (fin) begin
          e = '0;
          e.dump = 1'b1;
          push(u, e);
          mst[u] = 2;
        end
      end
      2: mst[u] = 3;
      3, 0: if (start[u]) begin
        mst[u] = 1;
        for (int k = 0; k < NR; k++) mcnt[u][k] = 0;
      end
      default: ;
    endcase
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      mst[u]  = 0;
      mptr[u] = 0;
      for (int k = 0; k < NR; k++) mcnt[u][k] = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  // called at a falling edge, returns at the next one
  task automatic step();
    #1;
    model(0);
    model(1);
    @(negedge clock);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_wr"},   64'(b0.ofm_write), 64'd0);
    chk({tag, "_wo"},   64'(b0.ofm_write_out), 64'd0);
    chk({tag, "_addr"}, 64'(b0.ofm_address), 64'd0);
    chk({tag, "_off"},  64'(b0.ofm_offset), 64'd0);
    chk({tag, "_data"}, 64'(b0.ofm_data), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
  endtask

  // asynchronous reset asserted mid-cycle
  task automatic rst_pulse(string tag);
    #3 rst_n = 1'b0;
    #1 chk_zero(tag);
    model_reset();
    @(negedge clock);
    rst_n = 1'b1;
  endtask

  task automatic small_layer(string tag);
    start[1] = 1'b1;
    step();
    start[1] = 1'b0;
    vld[1] = 4'b1111;
    dat[1] = 32'hD3C2B1A0;
    for (int k = 0; k < 8; k++) begin
      #1 chk({tag, "_grant"}, 64'(b1.req_ready),
             64'(1) << (k % 4));
      step();
      dat[1] = dat[1] + 32'h01010101;
    end
    for (int k = 0; k < 4; k++) step();
    chk({tag, "_done"}, 64'(done[1]), 64'd1);
    vld[1] = '0;
  endtask

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #2 chk_zero("reset");
    @(negedge clock);
    rst_n = 1'b1;

    // engine 2 alone streams a full layer share
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    vld[0] = 4'b0100;
    for (int k = 0; k < 128; k++) begin
      dat[0][23:16] = 8'(8'h10 + k);
      step();
    end
    #1 chk("t1_sat", 64'(b0.req_ready), 64'd0);
    step();
    vld[0] = '0;
    step();

    // engines 0 and 2 alternate, engine 1 joins later
    rst_pulse("t3_rst");
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    vld[0] = 4'b0101;
    for (int k = 0; k < 10; k++) begin
      dat[0] = {4{8'(k)}} ^ 32'h30201000;
      #1 chk("t3_alt", 64'(b0.req_ready),
             (k % 2 == 1) ? 64'd4 : 64'd1);
      step();
    end
    vld[0] = 4'b0111;
    for (int k = 0; k < 4; k++) begin
      dat[0] = {4{8'(8'h80 + k)}};
      #1 chk("t3_join", 64'(b0.req_ready),
             (k == 1) ? 64'd2 : (k == 2) ? 64'd4 : 64'd1);
      step();
    end

    // engine 0 saturates yet keeps valid high
    vld[0] = 4'b0001;
    for (int k = 0; k < 130; k++) begin
      dat[0][7:0] = 8'(8'hC0 ^ k);
      step();
    end
    #1 chk("t4_sat", 64'(b0.req_ready), 64'd0);
    step();

    // start mid-run is ignored, then async abort
    start[0] = 1'b1;
    vld[0] = 4'b0100;
    step();
    start[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      dat[0][23:16] = 8'(8'h55 + k);
      step();
    end
    rst_pulse("t5_rst");
    vld[0] = 4'b1111;
    for (int k = 0; k < 20; k++) step();
    vld[0] = '0;

    // two back-to-back small layers
    small_layer("t2");
    small_layer("t6");

    for (int k = 0; k < 3; k++) step();
    chk("q0_empty", 64'(q0.size()), 64'd0);
    chk("q1_empty", 64'(q1.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
